execute_stage: RTL and testbench

Pipeline execute stage; sits directly upstream of the memory-access stage and drives its control_ex/result_ex/reg_data_ex/dest_reg_index_ex/dest_reg_write_en_ex inputs. Performs single-cycle ALU ops, load/store address generation and an iterative 16-cycle shift-add multiply. Multiply stalls the decode stage via stall_ex and bubbles the pipeline. Flush aborts any in-flight op.

---
 rtl/execute_stage.sv | 179 +++++++++++++++++
 tb/tb_execute_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, load/store address generation, iterative shift-add multiply.
// Latency: 1 cycle for ALU/LOAD/STORE; MUL occupies 18 cycles (17 bubbles, then the product).
// Backpressure: stall_ex holds decode while a multiply is pending; flush overrides and drops it.
module execute_stage #(
    parameter int WIDTH      = 16,
    parameter int REG_IDX_W  = 5,
    parameter int MUL_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [3:0]           control_id,
    input  logic [WIDTH-1:0]     operand_a_id,
    input  logic [WIDTH-1:0]     operand_b_id,
    input  logic [WIDTH-1:0]     reg_data_id,
    input  logic [REG_IDX_W-1:0] dest_reg_index_id,
    input  logic                 dest_reg_write_en_id,
    input  logic                 flush,
    output logic                 stall_ex,
    output logic [3:0]           control_ex,
    output logic [WIDTH-1:0]     result_ex,
    output logic [WIDTH-1:0]     reg_data_ex,
    output logic [REG_IDX_W-1:0] dest_reg_index_ex,
    output logic                 dest_reg_write_en_ex,
    output logic                 busy
);
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    localparam int SH_W  = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_LI    = 4'b1010;
    localparam logic [3:0] OP_MOV   = 4'b1011;
    localparam logic [3:0] OP_LOAD  = 4'b1100;
    localparam logic [3:0] OP_STORE = 4'b1110;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     count;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [WIDTH-1:0]     acc;
    logic [WIDTH-1:0]     mul_rd;
    logic [REG_IDX_W-1:0] mul_idx;
    logic                 mul_we;

    logic [SH_W-1:0]      shamt;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_we;

    logic [3:0]           ctl_nxt;
    logic [WIDTH-1:0]     res_nxt;
    logic [WIDTH-1:0]     rd_nxt;
    logic [REG_IDX_W-1:0] idx_nxt;
    logic                 we_nxt;

    logic mul_start;

    assign shamt     = operand_b_id[SH_W-1:0];
    assign mul_start = (state == S_IDLE) && (control_id == OP_MUL);
    // Reset and flush both mask the stall so decode is never held by a dead op.
    assign stall_ex  = reset_n && !flush && (mul_start || (state == S_BUSY));

    always_comb begin
        alu_res = '0;
        alu_we  = dest_reg_write_en_id;
        case (control_id)
            OP_ADD:   alu_res = operand_a_id + operand_b_id;
            OP_SUB:   alu_res = operand_a_id - operand_b_id;
            OP_AND:   alu_res = operand_a_id & operand_b_id;
            OP_OR:    alu_res = operand_a_id | operand_b_id;
            OP_XOR:   alu_res = operand_a_id ^ operand_b_id;
            OP_NOT:   alu_res = ~operand_a_id;
            OP_SLL:   alu_res = operand_a_id << shamt;
            OP_SRL:   alu_res = operand_a_id >> shamt;
            OP_SRA:   alu_res = $signed(operand_a_id) >>> shamt;
            OP_LI:    alu_res = operand_b_id;
            OP_MOV:   alu_res = operand_a_id;
            OP_LOAD:  alu_res = operand_a_id + operand_b_id;
            OP_STORE: begin
                alu_res = operand_a_id + operand_b_id;
                alu_we  = 1'b0;
            end
            default:  alu_we = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        ctl_nxt   = OP_NOP;
        res_nxt   = '0;
        rd_nxt    = '0;
        idx_nxt   = '0;
        we_nxt    = 1'b0;
        if (flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (control_id == OP_MUL) begin
                        state_nxt = S_BUSY;
                    end else begin
                        ctl_nxt = control_id;
                        res_nxt = alu_res;
                        rd_nxt  = reg_data_id;
                        idx_nxt = dest_reg_index_id;
                        we_nxt  = alu_we;
                    end
                end
                S_BUSY: begin
                    if (count == CNT_W'(MUL_CYCLES - 1)) state_nxt = S_DONE;
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                    ctl_nxt   = OP_MUL;
                    res_nxt   = acc;
                    rd_nxt    = mul_rd;
                    idx_nxt   = mul_idx;
                    we_nxt    = mul_we;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            busy                 <= 1'b0;
            count                <= '0;
            mcand                <= '0;
            mplier               <= '0;
            acc                  <= '0;
            mul_rd               <= '0;
            mul_idx              <= '0;
            mul_we               <= 1'b0;
            control_ex           <= OP_NOP;
            result_ex            <= '0;
            reg_data_ex          <= '0;
            dest_reg_index_ex    <= '0;
            dest_reg_write_en_ex <= 1'b0;
        end else begin
            state                <= state_nxt;
            busy                 <= (state_nxt != S_IDLE);
            control_ex           <= ctl_nxt;
            result_ex            <= res_nxt;
            reg_data_ex          <= rd_nxt;
            dest_reg_index_ex    <= idx_nxt;
            dest_reg_write_en_ex <= we_nxt;
            if (flush) begin
                count <= '0;
            end else if (mul_start) begin
                mcand   <= operand_a_id;
                mplier  <= operand_b_id;
                acc     <= '0;
                count   <= '0;
                mul_rd  <= reg_data_id;
                mul_idx <= dest_reg_index_id;
                mul_we  <= dest_reg_write_en_id;
            end else if (state == S_BUSY) begin
                // Product is taken modulo 2^WIDTH, so bits shifted out of mcand are irrelevant.
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                count  <= count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: scoreboarded output checks for ALU, store, multiply, flush and reset.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  control_id;
    logic [15:0] operand_a_id, operand_b_id, reg_data_id;
    logic [4:0]  dest_reg_index_id;
    logic        dest_reg_write_en_id;
    logic        flush;
    logic        stall_ex;
    logic [3:0]  control_ex;
    logic [15:0] result_ex, reg_data_ex;
    logic [4:0]  dest_reg_index_ex;
    logic        dest_reg_write_en_ex;
    logic        busy;

    typedef struct packed {
        logic [3:0]  ctl;
        logic [15:0] res;
        logic [15:0] rd;
        logic [4:0]  idx;
        logic        we;
    } out_t;

    localparam out_t BUBBLE = '{ctl: 4'hF, res: 16'h0, rd: 16'h0, idx: 5'd0, we: 1'b0};

    out_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    execute_stage dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .control_id           (control_id),
        .operand_a_id         (operand_a_id),
        .operand_b_id         (operand_b_id),
        .reg_data_id          (reg_data_id),
        .dest_reg_index_id    (dest_reg_index_id),
        .dest_reg_write_en_id (dest_reg_write_en_id),
        .flush                (flush),
        .stall_ex             (stall_ex),
        .control_ex           (control_ex),
        .result_ex            (result_ex),
        .reg_data_ex          (reg_data_ex),
        .dest_reg_index_ex    (dest_reg_index_ex),
        .dest_reg_write_en_ex (dest_reg_write_en_ex),
        .busy                 (busy)
    );

    function automatic out_t observed();
        return '{ctl: control_ex, res: result_ex, rd: reg_data_ex,
                 idx: dest_reg_index_ex, we: dest_reg_write_en_ex};
    endfunction

    task automatic drive(input logic [3:0] ctl, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] rd, input logic [4:0] idx, input logic we);
        control_id           = ctl;
        operand_a_id         = a;
        operand_b_id         = b;
        reg_data_id          = rd;
        dest_reg_index_id    = idx;
        dest_reg_write_en_id = we;
    endtask

    task automatic test_reset();
        out_t got, e;
        reset_n = 1'b0;
        flush   = 1'b0;
        drive(4'hF, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        got = observed();
        n_cmp++;
        if (got !== BUBBLE) begin
            n_bad++;
            $display("FAIL reset_initial: got %h expected %h", got, BUBBLE);
        end
        reset_n = 1'b1;
        @(negedge clk);
        drive(4'h0, 16'h0001, 16'h0002, 16'h1111, 5'd3, 1'b1);
        exp_q.push_back('{ctl: 4'h0, res: 16'h0003, rd: 16'h1111, idx: 5'd3, we: 1'b1});
        @(posedge clk);
        #1;
        got = observed();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL reset_pre_add: got %h expected %h", got, e);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        got = observed();
        n_cmp++;
        if (got !== BUBBLE) begin
            n_bad++;
            $display("FAIL reset_midcycle: got %h expected %h", got, BUBBLE);
        end
        n_cmp++;
        if (stall_ex !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_stall_busy: got stall=%b busy=%b expected 0 0", stall_ex, busy);
        end
        drive(4'hF, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        we;
    } alu_vec_t;

    task automatic test_alu();
        alu_vec_t tbl[14];
        out_t got, e;
        logic [15:0] rdv;
        logic [4:0]  idxv;
        tbl[0]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tbl[1]  = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1};
        tbl[2]  = '{4'h8, 16'h8000, 16'h0004, 16'hF800, 1'b1};
        tbl[3]  = '{4'h7, 16'h8000, 16'h0004, 16'h0800, 1'b1};
        tbl[4]  = '{4'h6, 16'h0001, 16'h000F, 16'h8000, 1'b1};
        tbl[5]  = '{4'h6, 16'h1234, 16'h0014, 16'h2340, 1'b1};
        tbl[6]  = '{4'h2, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1};
        tbl[7]  = '{4'h3, 16'hF0F0, 16'h0F0F, 16'hFFFF, 1'b1};
        tbl[8]  = '{4'h4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b1};
        tbl[9]  = '{4'h5, 16'h00FF, 16'h1234, 16'hFF00, 1'b1};
        tbl[10] = '{4'hA, 16'h1234, 16'hABCD, 16'hABCD, 1'b1};
        tbl[11] = '{4'hB, 16'h1234, 16'hABCD, 16'h1234, 1'b1};
        tbl[12] = '{4'hC, 16'h1000, 16'h0020, 16'h1020, 1'b1};
        tbl[13] = '{4'hD, 16'h1234, 16'h5678, 16'h0000, 1'b0};
        for (int i = 0; i < 14; i++) begin
            rdv  = (tbl[i].op == 4'hD) ? 16'h0 : 16'h1000 + 16'(i);
            idxv = (tbl[i].op == 4'hD) ? 5'd0 : 5'(i + 1);
            @(negedge clk);
            drive(tbl[i].op, tbl[i].a, tbl[i].b, rdv, idxv, 1'b1);
            exp_q.push_back('{ctl: tbl[i].op, res: tbl[i].res, rd: rdv, idx: idxv, we: tbl[i].we});
            #1;
            n_cmp++;
            if (stall_ex !== 1'b0) begin
                n_bad++;
                $display("FAIL alu_stall[%0d]: got %b expected 0", i, stall_ex);
            end
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL alu[%0d] op=%h: got %h expected %h", i, tbl[i].op, got, e);
            end
        end
    endtask

    task automatic test_store();
        out_t got, e;
        @(negedge clk);
        drive(4'hE, 16'h0003, 16'h0004, 16'hBEEF, 5'd9, 1'b1);
        exp_q.push_back('{ctl: 4'hE, res: 16'h0007, rd: 16'hBEEF, idx: 5'd9, we: 1'b0});
        @(posedge clk);
        #1;
        got = observed();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL store: got %h expected %h", got, e);
        end
    endtask

    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input logic [15:0] rd,
                           input logic [4:0] idx, input logic [15:0] product);
        out_t got, e;
        int   stall_cycles = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 0) drive(4'h9, a, b, rd, idx, 1'b1);
            exp_q.push_back((c < 17) ? BUBBLE :
                            '{ctl: 4'h9, res: product, rd: rd, idx: idx, we: 1'b1});
            #1;
            if (stall_ex === 1'b1) stall_cycles++;
            n_cmp++;
            if (stall_ex !== (c < 17) || busy !== (c > 0)) begin
                n_bad++;
                $display("FAIL mul_ctl %h*%h cyc%0d: got stall=%b busy=%b expected %b %b",
                         a, b, c, stall_ex, busy, (c < 17), (c > 0));
            end
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL mul_out %h*%h cyc%0d: got %h expected %h", a, b, c, got, e);
            end
        end
        n_cmp++;
        if (stall_cycles != 17) begin
            n_bad++;
            $display("FAIL mul_stall_len %h*%h: got %0d expected 17", a, b, stall_cycles);
        end
    endtask

    task automatic test_mul();
        out_t got, e;
        run_mul(16'd123, 16'd45, 16'h0042, 5'd5, 16'd5535);
        @(negedge clk);
        drive(4'h0, 16'h0010, 16'h0020, 16'h0000, 5'd7, 1'b1);
        exp_q.push_back('{ctl: 4'h0, res: 16'h0030, rd: 16'h0000, idx: 5'd7, we: 1'b1});
        @(posedge clk);
        #1;
        got = observed();
        e   = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_bad++;
            $display("FAIL mul_then_add: got %h expected %h", got, e);
        end
    endtask

    task automatic test_back_to_back();
        run_mul(16'hFFFF, 16'hFFFF, 16'h1234, 5'd17, 16'h0001);
        run_mul(16'h0100, 16'h0100, 16'h5678, 5'd31, 16'h0000);
    endtask

    task automatic test_flush();
        out_t got, e;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 0) drive(4'h9, 16'd7, 16'd9, 16'h0AAA, 5'd2, 1'b1);
            if (c == 8) flush = 1'b1;
            exp_q.push_back(BUBBLE);
            #1;
            n_cmp++;
            if (stall_ex !== (c < 8)) begin
                n_bad++;
                $display("FAIL flush_stall cyc%0d: got %b expected %b", c, stall_ex, (c < 8));
            end
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL flush_out cyc%0d: got %h expected %h", c, got, e);
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_busy: got %b expected 0", busy);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            flush = 1'b0;
            drive(4'hF, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
            exp_q.push_back(BUBBLE);
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL flush_after cyc%0d: got %h busy=%b expected %h busy=0", c, got, busy, e);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        out_t got, e;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) drive(4'h9, 16'd300, 16'd11, 16'h0BBB, 5'd4, 1'b1);
            exp_q.push_back(BUBBLE);
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_bad++;
                $display("FAIL rstmul_out cyc%0d: got %h expected %h", c, got, e);
            end
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        got = observed();
        n_cmp++;
        if (got !== BUBBLE || stall_ex !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmul_reset: got %h stall=%b busy=%b expected %h 0 0",
                     got, stall_ex, busy, BUBBLE);
        end
        @(negedge clk);
        drive(4'hF, 16'h0, 16'h0, 16'h0, 5'd0, 1'b0);
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            exp_q.push_back(BUBBLE);
            @(posedge clk);
            #1;
            got = observed();
            e   = exp_q.pop_front();
            n_cmp++;
            if (got !== e || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmul_after cyc%0d: got %h busy=%b expected %h busy=0", c, got, busy, e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_store();
        test_mul();
        test_back_to_back();
        test_flush();
        test_reset_mid_mul();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
